// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants for the fetch stage
//
// Purpose: word width, the bubble instruction and the major opcode values
// used by the pipeline front end.
// Ports: none (package).
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // add x0,x0,x0 : architecturally a no-op, used for pipeline bubbles
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold and flush
//
// Purpose: holds the PC, instruction word and valid bit handed from fetch
// to decode. A flush loads a bubble (NOP, valid=0) tagged with pc_in and
// takes priority over hold; otherwise load_en selects load versus hold.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load_en              capture pc_in/instr_in/valid_in
//   flush                capture pc_in with a bubble (overrides load_en)
//   pc_in, instr_in      fetch PC and instruction word
//   valid_in             fetched word is a real instruction
//   pc_q, instr_q, valid_q  registered IF/ID contents
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE = 32'h0000_0033
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic            valid_in,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] instr_q,
  output logic            valid_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (flush) begin
      pc_q    <= pc_in;
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (load_en) begin
      pc_q    <= pc_in;
      instr_q <= instr_in;
      valid_q <= valid_in;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, next-PC mux, IF/ID latch
//
// Purpose: owns the program counter, presents the word address to a
// zero-latency instruction memory and latches the returned word into IF/ID.
// Branch redirect (with flush) beats decode stall, which beats sequential
// fetch. Fetches beyond the memory depth produce bubbles without wrapping.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hold PC, IF/ID and fetch_count
//   branch_taken    redirect to branch_target and flush IF/ID
//   branch_target   redirect byte address (low two bits dropped)
//   imem_addr       word address to instruction memory (pc[ADDR_W+1:2])
//   imem_data       instruction word returned combinationally
//   pc              current fetch PC
//   if_id_pc, if_id_instr, if_id_valid  IF/ID contents
//   misalign_err    sticky flag: some redirect target was not word aligned
//   fetch_count     count of valid instructions written into IF/ID
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     ADDR_W    = 6,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0,
  parameter logic [XLEN-1:0] NOP_WORD  = riscv_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_instr,
  output logic              if_id_valid,
  output logic              misalign_err,
  output logic [XLEN-1:0]   fetch_count
);

  logic            in_range;
  logic [XLEN-1:0] fetch_word;

  assign imem_addr = pc[ADDR_W+1:2];

  // Compare the full word index against the depth so addresses past the
  // memory are detected instead of aliasing onto low words.
  assign in_range   = ({1'b0, (pc >> 2)} < (33'd1 << ADDR_W));
  assign fetch_word = in_range ? imem_data : NOP_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else if (branch_taken) begin
      pc           <= {branch_target[XLEN-1:2], 2'b00};
      misalign_err <= misalign_err | (branch_target[1:0] != 2'b00);
    end else if (!stall) begin
      pc <= pc + 32'd4;
      if (in_range) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_reg #(
    .BUBBLE (NOP_WORD)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (!stall),
    .flush    (branch_taken),
    .pc_in    (pc),
    .instr_in (fetch_word),
    .valid_in (in_range),
    .pc_q     (if_id_pc),
    .instr_q  (if_id_instr),
    .valid_q  (if_id_valid)
  );

endmodule
